// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing arbiter: op encodings, legality check, FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  function automatic logic alu_legal(input logic [2:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: alu_legal = 1'b1;
      default:                                    alu_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU; undefined ops yield zero and are masked by the caller.
module alu_share_arbiter_alu
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_ctrl,
  output logic [31:0] o_result,
  output logic        o_zero
);

  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      // SLT compares as unsigned.
      ALU_SLT: o_result = {31'd0, (i_a < i_b)};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters, one registered response in flight.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter logic RR_INIT   = 1'b0,
  parameter logic ILLEGAL_Z = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_ctrl,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic        rsp1_err,
  output logic        busy,
  output state_t      o_dbg_state
);

  // Handshake: a request transfers on an edge where reqN_valid & reqN_ready; a response
  // transfers where rspN_valid & rspN_ready. Responses hold steady until consumed.

  state_t      r_state;
  logic        r_owner;
  logic        r_prio;
  logic [1:0]  r_rsp_valid;
  logic [31:0] r_rsp_result [2];
  logic [1:0]  r_rsp_zero;
  logic [1:0]  r_rsp_err;

  logic        w_any;
  logic        w_gnt;
  logic        w_rsp_hs;
  logic        w_can_accept;
  logic        w_accept;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [2:0]  w_ctrl;
  logic [31:0] w_alu_result;
  logic        w_alu_zero;
  logic        w_legal;
  logic [31:0] w_result;
  logic        w_zero;
  logic        w_owner_ready;

  assign w_any         = req0_valid | req1_valid;
  assign w_gnt         = (req0_valid & req1_valid) ? r_prio : req1_valid;
  assign w_owner_ready = r_owner ? rsp1_ready : rsp0_ready;
  assign w_rsp_hs      = (r_state == RESP) & r_rsp_valid[r_owner] & w_owner_ready;
  assign w_can_accept  = (r_state == IDLE) | w_rsp_hs;
  assign w_accept      = w_can_accept & w_any;

  assign req0_ready = w_can_accept & w_any & ~w_gnt;
  assign req1_ready = w_can_accept & w_any & w_gnt;

  assign w_a    = w_gnt ? req1_a    : req0_a;
  assign w_b    = w_gnt ? req1_b    : req0_b;
  assign w_ctrl = w_gnt ? req1_ctrl : req0_ctrl;

  alu_share_arbiter_alu u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_ctrl   (w_ctrl),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  assign w_legal  = alu_legal(w_ctrl);
  assign w_result = w_legal ? w_alu_result : 32'd0;
  assign w_zero   = w_legal ? w_alu_zero   : ILLEGAL_Z;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_owner         <= 1'b0;
      r_prio          <= RR_INIT;
      r_rsp_valid     <= '0;
      r_rsp_result[0] <= '0;
      r_rsp_result[1] <= '0;
      r_rsp_zero      <= '0;
      r_rsp_err       <= '0;
    end else if (w_accept) begin
      // Accept may coincide with the previous owner's handshake; the loser's slot is cleared.
      r_state                <= RESP;
      r_owner                <= w_gnt;
      r_prio                 <= ~w_gnt;
      r_rsp_valid[w_gnt]     <= 1'b1;
      r_rsp_valid[~w_gnt]    <= 1'b0;
      r_rsp_result[w_gnt]    <= w_result;
      r_rsp_result[~w_gnt]   <= '0;
      r_rsp_zero[w_gnt]      <= w_zero;
      r_rsp_zero[~w_gnt]     <= 1'b0;
      r_rsp_err[w_gnt]       <= ~w_legal;
      r_rsp_err[~w_gnt]      <= 1'b0;
    end else if (w_rsp_hs) begin
      r_state     <= IDLE;
      r_rsp_valid <= '0;
    end
  end

  assign rsp0_valid  = r_rsp_valid[0];
  assign rsp0_result = r_rsp_result[0];
  assign rsp0_zero   = r_rsp_zero[0];
  assign rsp0_err    = r_rsp_err[0];
  assign rsp1_valid  = r_rsp_valid[1];
  assign rsp1_result = r_rsp_result[1];
  assign rsp1_zero   = r_rsp_zero[1];
  assign rsp1_err    = r_rsp_err[1];
  assign busy        = (r_state == RESP);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reset, single ops, contention, backpressure, illegal, withdrawal.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic        busy;
  state_t      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] t3_exp [4];

  alu_share_arbiter #(.RR_INIT(1'b0), .ILLEGAL_Z(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ctrl   (req0_ctrl),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ctrl   (req1_ctrl),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp0_err    (rsp0_err),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .rsp1_err    (rsp1_err),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, time=%0t required=<100000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic drive_req(input int n, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] ctrl);
    if (n == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = ctrl;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = ctrl;
    end
  endtask

  initial begin
    t3_exp[0] = 32'd10;   // req0 ADD 0+10
    t3_exp[1] = 32'd17;   // req1 OR 16|1
    t3_exp[2] = 32'd12;   // req0 ADD 2+10
    t3_exp[3] = 32'd49;   // req1 OR 48|1

    reset = 1'b0;
    drive_req(0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive_req(1, 1'b0, 32'd0, 32'd0, 3'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp0_result", rsp0_result, 32'd0);
    check("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    reset = 1'b1;

    // T2: SUB 5-3 and unsigned SLT 3<5
    @(negedge clk);
    drive_req(0, 1'b1, 32'd5, 32'd3, ALU_SUB);
    #1 check("t2_req0_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    check("t2_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("t2_sub_result", rsp0_result, 32'd2);
    check("t2_sub_zero", {31'd0, rsp0_zero}, 32'd0);
    check("t2_sub_err", {31'd0, rsp0_err}, 32'd0);
    check("t2_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("t2_busy", {31'd0, busy}, 32'd1);
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("t2_idle_busy", {31'd0, busy}, 32'd0);
    check("t2_idle_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    drive_req(0, 1'b1, 32'd3, 32'd5, ALU_SLT);
    @(negedge clk);
    req0_valid = 1'b0;
    check("t2_slt_valid", {31'd0, rsp0_valid}, 32'd1);
    check("t2_slt_result", rsp0_result, 32'd1);
    @(negedge clk);
    check("t2_slt_done", {31'd0, busy}, 32'd0);

    // T1: reset while a response for req1 is pending
    rsp0_ready = 1'b0;
    drive_req(1, 1'b1, 32'd1, 32'd1, ALU_ADD);
    @(negedge clk);
    req1_valid = 1'b0;
    check("t1_rsp1_valid_pre", {31'd0, rsp1_valid}, 32'd1);
    check("t1_rsp1_result_pre", rsp1_result, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("t1_rsp1_valid_rst", {31'd0, rsp1_valid}, 32'd0);
    check("t1_busy_rst", {31'd0, busy}, 32'd0);
    check("t1_rsp1_result_rst", rsp1_result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive_req(0, 1'b1, 32'd0, 32'd10, ALU_ADD);
    #1 check("t1_req0_ready_after", {31'd0, req0_ready}, 32'd1);

    // T3: both valid every cycle, grants alternate from RR_INIT=0
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          check("t3_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
          check("t3_rsp0_result", rsp0_result, t3_exp[i-1]);
        end else begin
          check("t3_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
          check("t3_rsp1_result", rsp1_result, t3_exp[i-1]);
        end
      end
      drive_req(0, 1'b1, i, 32'd10, ALU_ADD);
      drive_req(1, 1'b1, i * 16, 32'd1, ALU_OR);
      #1;
      check("t3_req0_ready", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("t3_req1_ready", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t3_last_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("t3_last_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("t3_last_result", rsp1_result, t3_exp[3]);
    @(negedge clk);
    check("t3_idle", {31'd0, busy}, 32'd0);

    // T4: backpressure on rsp1 with wrapping ADD
    rsp1_ready = 1'b0;
    drive_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
    @(negedge clk);
    drive_req(0, 1'b1, 32'hF0, 32'hFF, ALU_AND);
    drive_req(1, 1'b1, 32'd1, 32'd2, ALU_SLT);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check("t4_rsp1_result", rsp1_result, 32'd0);
      check("t4_rsp1_zero", {31'd0, rsp1_zero}, 32'd1);
      check("t4_req0_ready", {31'd0, req0_ready}, 32'd0);
      check("t4_req1_ready", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    #1;
    check("t4_hs_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("t4_hs_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    check("t4_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("t4_rsp1_dropped", {31'd0, rsp1_valid}, 32'd0);
    check("t4_rsp0_result", rsp0_result, 32'h0000_00F0);
    check("t4_rsp1_cleared", rsp1_result, 32'd0);
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    check("t4_slt_valid", {31'd0, rsp1_valid}, 32'd1);
    check("t4_slt_result", rsp1_result, 32'd1);
    @(negedge clk);
    check("t4_idle", {31'd0, busy}, 32'd0);

    // T5: illegal op, then contention must favour req1
    rsp0_ready = 1'b0;
    drive_req(0, 1'b1, 32'd9, 32'd9, 3'b100);
    @(negedge clk);
    req0_valid = 1'b0;
    check("t5_err", {31'd0, rsp0_err}, 32'd1);
    check("t5_result", rsp0_result, 32'd0);
    check("t5_zero", {31'd0, rsp0_zero}, 32'd1);
    drive_req(0, 1'b1, 32'd1, 32'd1, ALU_AND);
    drive_req(1, 1'b1, 32'd7, 32'd8, ALU_ADD);
    rsp0_ready = 1'b1;
    #1;
    check("t5_req1_ready", {31'd0, req1_ready}, 32'd1);
    check("t5_req0_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t5_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("t5_rsp1_result", rsp1_result, 32'd15);
    check("t5_rsp1_err", {31'd0, rsp1_err}, 32'd0);
    check("t5_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    @(negedge clk);
    check("t5_idle", {31'd0, busy}, 32'd0);

    // T6: req1 pulses valid while req0 response is held
    rsp0_ready = 1'b0;
    drive_req(0, 1'b1, 32'd1, 32'd2, ALU_OR);
    @(negedge clk);
    req0_valid = 1'b0;
    drive_req(1, 1'b1, 32'd4, 32'd4, ALU_ADD);
    #1 check("t6_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req1_valid = 1'b0;
    check("t6_rsp0_result", rsp0_result, 32'd3);
    rsp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_rsp1_never", {31'd0, rsp1_valid}, 32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
